mcdf_slave_fifo: RTL and testbench
==================================

MCDF_SLAVE_FIFO -- requirements
Module: mcdf_slave_fifo

Interface
REQ-001 SHALL have the port: clk  input  1  single clock; all logic on posedge.
REQ-002 SHALL have the port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have the port: slv_en  input  1  channel enable; 0 blocks new writes and new packet requests.
REQ-004 SHALL have the port: pkt_len_sel  input  2  packet length code: 0=4, 1=8, 2=16, 3=32 words.
REQ-005 SHALL have the port: ch_data  input  32  channel write data.
REQ-006 SHALL have the port: ch_valid  input  1  channel write data valid.
REQ-007 SHALL have the port: ch_ready  output  1  FIFO accepts ch_data this cycle.
REQ-008 SHALL have the port: slv_req  output  1  complete packet available, requesting the arbiter.
REQ-009 SHALL have the port: a2s_ack  input  1  arbiter grant, single-cycle pulse.
REQ-010 SHALL have the port: slv_data  output  32  packet word to the arbiter.
REQ-011 SHALL have the port: slv_val  output  1  slv_data valid.
REQ-012 SHALL have the port: slv_last  output  1  final word of the packet.
REQ-013 SHALL have the port: slv_margin  output  6  free FIFO entries, 0..32.

Function
REQ-014 SHALL buffer data in a 32-deep x 32-bit FIFO.
REQ-015 SHALL assert ch_ready = slv_en && !full, computed combinationally from registered state.
REQ-016 SHALL write ch_data on any cycle with ch_valid && ch_ready; ch_valid while ch_ready=0 SHALL be ignored, not stored.
REQ-017 SHALL wrap read/write pointers modulo 32 and distinguish full from empty with an extra pointer bit or a count.
REQ-018 SHALL implement FSM IDLE -> REQ -> SEND -> IDLE.
REQ-019 SHALL, in IDLE, move to REQ when slv_en=1 and count >= words(pkt_len_sel), latching words(pkt_len_sel) into a burst counter.
REQ-020 SHALL register slv_req so it is 1 exactly while in REQ, and hold it until a2s_ack.
REQ-021 SHALL ignore a2s_ack outside REQ.
REQ-022 SHALL, in REQ, move to SEND on the cycle after a2s_ack=1.
REQ-023 SHALL, in SEND, register outputs so slv_val=1 for exactly N consecutive cycles (N = latched length), present FIFO words in write order, pop one word per cycle, and set slv_last=1 on the Nth word only.
REQ-024 SHALL return to IDLE after the last word; the earliest next slv_req is one cycle after slv_last.
REQ-025 SHALL ignore pkt_len_sel changes after REQ entry until the next IDLE evaluation.
REQ-026 SHALL, when slv_en drops mid-REQ or mid-SEND, drop ch_ready at once and still complete the pending request and packet.
REQ-027 SHALL, on a simultaneous write and pop, leave count unchanged and accept the write even when count=32 before the pop.
REQ-028 SHALL update slv_margin = 32 - count in the same cycle as count.

Reset
REQ-029 SHALL, on reset, clear pointers and count, enter IDLE, and set ch_ready, slv_req, slv_val and slv_last to 0, slv_data to 0, and slv_margin to 32.
REQ-030 SHALL give reset priority over all events; a reset asserted mid-SEND aborts the packet with no slv_last and discards FIFO contents.
REQ-031 SHALL assert ch_ready on the first cycle after reset deasserts when slv_en=1.

Structure
REQ-032 SHALL take DEPTH=32, DATA_W=32, the state enum (IDLE/REQ/SEND) and the pkt_len_sel->words function from shared package mcdf_pkg.
REQ-033 SHALL place storage, pointers and count in sub-module mcdf_sync_fifo (push/pop/full/empty/count); the FSM stays in mcdf_slave_fifo.

Verification
REQ-034 SHALL cover: pkt_len_sel=0, 4 writes 0xA0..0xA3 -> slv_req in IDLE+1; a2s_ack -> 4 slv_val cycles, data A0..A3, slv_last on A3.
REQ-035 SHALL cover: 33 back-to-back ch_valid, no ack -> ch_ready=0 after 32 writes, slv_margin=0, word 33 not stored.
REQ-036 SHALL cover: full FIFO, pkt_len_sel=3, ack, ch_valid held during SEND -> writes accepted each pop cycle, count stays 32 until ch_valid drops.
REQ-037 SHALL cover: slv_en=0 after ack, pkt_len_sel=1 -> ch_ready=0 immediately, 8-word packet completes, no further slv_req.
REQ-038 SHALL cover: reset on the 3rd SEND word of a 16-word packet -> next cycle slv_val=0, slv_margin=32, no slv_last.
REQ-039 SHALL cover: pkt_len_sel 0->3 while in REQ -> packet is still 4 words.

Source files
------------

// File: rtl/mcdf_pkg.sv
// -----------------------------------------------------------------------------
// mcdf_pkg
// Shared constants for the MCDF slave channel. It holds the FIFO geometry,
// the slave FSM state encoding, and the mapping from pkt_len_sel to a packet
// length in words.
// -----------------------------------------------------------------------------
package mcdf_pkg;

    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
    localparam int PTR_W  = 5;   // log2(DEPTH)
    localparam int CNT_W  = 6;   // holds 0..DEPTH inclusive

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_SEND = 2'd2;

    // Packet length code: 0=4, 1=8, 2=16, 3=32 words
    function automatic logic [CNT_W-1:0] pkt_words(input logic [1:0] sel);
        logic [CNT_W-1:0] words;
        case (sel)
            2'd0:    words = 6'd4;
            2'd1:    words = 6'd8;
            2'd2:    words = 6'd16;
            2'd3:    words = 6'd32;
            default: words = 6'd4;
        endcase
        return words;
    endfunction

endpackage

// File: rtl/mcdf_sync_fifo.sv
// -----------------------------------------------------------------------------
// mcdf_sync_fifo
// This is a single-clock FIFO (DEPTH x DATA_W) with an occupancy count.
// It has a show-ahead read: rdata is always the word at the read pointer.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (pointers/count)
//   push, wdata      : write request and data
//   pop              : read request; the head word is consumed this cycle
//   rdata            : current head word
//   full, empty      : occupancy flags derived from count
//   count            : number of stored words, 0..DEPTH
// A push is also taken while full when a pop happens in the same cycle.
// -----------------------------------------------------------------------------
module mcdf_sync_fifo
    import mcdf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign full  = (count_q == 6'd32);
    assign empty = (count_q == 6'd0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next-state pointers and count; 5-bit pointers wrap modulo DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + 5'd1;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + 5'd1;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + 6'd1;
            2'b01:   count_d = count_q - 6'd1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 5'd0;
            rd_ptr_q <= 5'd0;
            count_q  <= 6'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents become unreachable on reset through the pointers
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/mcdf_slave_fifo.sv
// -----------------------------------------------------------------------------
// mcdf_slave_fifo
// This is the MCDF slave channel. It buffers channel writes in a 32-entry
// FIFO. When a full packet is stored, it requests the arbiter. After the
// grant it streams the packet out, one word per cycle.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   slv_en               : channel enable (gates writes and new requests)
//   pkt_len_sel          : packet length code (4/8/16/32 words)
//   ch_data/ch_valid     : write side; ch_ready signals acceptance
//   slv_req / a2s_ack    : request to / grant from the arbiter
//   slv_data/val/last    : registered packet stream to the arbiter
//   slv_margin           : free FIFO entries (32 - count)
// The FIFO pops during every SEND cycle. The registered word appears on
// slv_data one cycle after its pop. On the last pop the FSM returns to IDLE,
// so slv_last shows while IDLE evaluates the next request.
// -----------------------------------------------------------------------------
module mcdf_slave_fifo
    import mcdf_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        slv_en,
    input  logic [1:0]  pkt_len_sel,
    input  logic [31:0] ch_data,
    input  logic        ch_valid,
    output logic        ch_ready,
    output logic        slv_req,
    input  logic        a2s_ack,
    output logic [31:0] slv_data,
    output logic        slv_val,
    output logic        slv_last,
    output logic [5:0]  slv_margin
);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  burst_q, burst_d;   // words still to pop in this packet
    logic              slv_req_q, slv_req_d;
    logic              slv_val_q, slv_val_d;
    logic              slv_last_q, slv_last_d;
    logic [DATA_W-1:0] slv_data_q, slv_data_d;

    logic              push_s;
    logic              pop_s;
    logic              full_s;
    logic              empty_s;
    logic [CNT_W-1:0]  count_s;
    logic [DATA_W-1:0] rdata_s;

    // Popping depends only on registered state. A write to a full FIFO is
    // therefore safe whenever a pop happens in the same cycle.
    assign pop_s    = (state_q == ST_SEND);
    assign ch_ready = slv_en && !reset && (!full_s || pop_s);
    assign push_s   = ch_valid && ch_ready;

    assign slv_req    = slv_req_q;
    assign slv_val    = slv_val_q;
    assign slv_last   = slv_last_q;
    assign slv_data   = slv_data_q;
    assign slv_margin = 6'd32 - count_s;

    mcdf_sync_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (ch_data),
        .rdata (rdata_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Packet FSM and registered output stream
    always_comb begin
        state_d    = state_q;
        burst_d    = burst_q;
        slv_req_d  = slv_req_q;
        slv_val_d  = 1'b0;
        slv_last_d = 1'b0;
        slv_data_d = slv_data_q;
        case (state_q)
            ST_IDLE: begin
                if (slv_en && (count_s >= pkt_words(pkt_len_sel))) begin
                    state_d   = ST_REQ;
                    burst_d   = pkt_words(pkt_len_sel);
                    slv_req_d = 1'b1;
                end else begin
                    slv_req_d = 1'b0;
                end
            end
            ST_REQ: begin
                if (a2s_ack) begin
                    state_d   = ST_SEND;
                    slv_req_d = 1'b0;
                end else begin
                    slv_req_d = 1'b1;
                end
            end
            ST_SEND: begin
                slv_val_d  = 1'b1;
                slv_data_d = rdata_s;
                burst_d    = burst_q - 6'd1;
                if (burst_q == 6'd1) begin
                    slv_last_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    slv_last_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                slv_req_d = 1'b0;
            end
        endcase
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            burst_q    <= 6'd0;
            slv_req_q  <= 1'b0;
            slv_val_q  <= 1'b0;
            slv_last_q <= 1'b0;
            slv_data_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            slv_req_q  <= slv_req_d;
            slv_val_q  <= slv_val_d;
            slv_last_q <= slv_last_d;
            slv_data_q <= slv_data_d;
        end
    end

endmodule

// File: tb/tb_mcdf_slave_fifo.sv
// -----------------------------------------------------------------------------
// tb_mcdf_slave_fifo
// Directed scenarios followed by randomized traffic. Every cycle's outputs are
// compared against a transaction-level reference model. The model holds a
// queue of stored words, a pending-request flag and a count of words left to
// stream.
// -----------------------------------------------------------------------------
module tb_mcdf_slave_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        slv_en;
    logic [1:0]  pkt_len_sel;
    logic [31:0] ch_data;
    logic        ch_valid;
    logic        a2s_ack;
    logic        ch_ready;
    logic        slv_req;
    logic [31:0] slv_data;
    logic        slv_val;
    logic        slv_last;
    logic [5:0]  slv_margin;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] mq[$];
    bit          m_req   = 1'b0;
    int          m_len   = 0;
    int          m_left  = 0;
    bit          e_val   = 1'b0;
    bit          e_last  = 1'b0;
    logic [31:0] e_data  = 32'd0;

    int obs_val_cnt;
    int obs_last_cnt;
    int obs_req_cnt;

    mcdf_slave_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .slv_en      (slv_en),
        .pkt_len_sel (pkt_len_sel),
        .ch_data     (ch_data),
        .ch_valid    (ch_valid),
        .ch_ready    (ch_ready),
        .slv_req     (slv_req),
        .a2s_ack     (a2s_ack),
        .slv_data    (slv_data),
        .slv_val     (slv_val),
        .slv_last    (slv_last),
        .slv_margin  (slv_margin)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs as seen at that edge.
    task automatic model_edge();
        int cnt;
        bit sending;
        bit idle;
        bit rdy;
        cnt     = mq.size();
        sending = (m_left > 0);
        idle    = !m_req && !sending;
        rdy     = slv_en && !reset && ((cnt < 32) || sending);
        if (reset) begin
            mq.delete();
            m_req  = 1'b0;
            m_left = 0;
            e_val  = 1'b0;
            e_last = 1'b0;
            e_data = 32'd0;
        end else begin
            e_val  = 1'b0;
            e_last = 1'b0;
            if (sending) begin
                e_data = mq.pop_front();
                e_val  = 1'b1;
                e_last = (m_left == 1);
                m_left = m_left - 1;
            end
            if (ch_valid && rdy) mq.push_back(ch_data);
            if (m_req) begin
                if (a2s_ack) begin
                    m_req  = 1'b0;
                    m_left = m_len;
                end
            end else if (idle && slv_en && (cnt >= (4 << pkt_len_sel))) begin
                m_req = 1'b1;
                m_len = 4 << pkt_len_sel;
            end
        end
    endtask

    task automatic check_outputs();
        bit rdy_exp;
        rdy_exp = slv_en && !reset && ((mq.size() < 32) || (m_left > 0));
        check_eq("ch_ready",   ch_ready,   rdy_exp);
        check_eq("slv_req",    slv_req,    m_req);
        check_eq("slv_val",    slv_val,    e_val);
        check_eq("slv_last",   slv_last,   e_last);
        check_eq("slv_data",   slv_data,   e_data);
        check_eq("slv_margin", slv_margin, 32 - mq.size());
        if (slv_val === 1'b1) obs_val_cnt++;
        if (slv_last === 1'b1) obs_last_cnt++;
        if (slv_req === 1'b1) obs_req_cnt++;
    endtask

    task automatic tick(input logic en, input logic [1:0] sel, input logic [31:0] d,
                        input logic v, input logic a, input logic r);
        slv_en      = en;
        pkt_len_sel = sel;
        ch_data     = d;
        ch_valid    = v;
        a2s_ack     = a;
        reset       = r;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        tick(1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic write_words(input logic [1:0] sel, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) tick(1'b1, sel, base + i, 1'b1, 1'b0, 1'b0);
    endtask

    // Idle until the model expects a request; an expired bound is a failure.
    task automatic wait_req(input logic en, input logic [1:0] sel);
        int n;
        n = 0;
        while (!m_req && n < 100) begin
            tick(en, sel, 32'd0, 1'b0, 1'b0, 1'b0);
            n++;
        end
        check_eq("req_wait", slv_req, 1'b1);
    endtask

    task automatic idle_cycles(input logic en, input logic [1:0] sel, input int n);
        for (int i = 0; i < n; i++) tick(en, sel, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        slv_en = 1'b1; pkt_len_sel = 2'd0; ch_data = 32'd0;
        ch_valid = 1'b0; a2s_ack = 1'b0; reset = 1'b1;

        // Reset state
        do_reset();
        check_eq("rst_margin", slv_margin, 32'd32);
        check_eq("rst_ready",  ch_ready,   1'b0);
        tick(1'b1, 2'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        check_eq("ready_after_rst", ch_ready, 1'b1);

        // 4-word packet A0..A3
        write_words(2'd0, 32'hA0, 4);
        wait_req(1'b1, 2'd0);
        obs_val_cnt = 0; obs_last_cnt = 0;
        tick(1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle_cycles(1'b1, 2'd0, 8);
        check_eq("pkt4_vals",  obs_val_cnt,  4);
        check_eq("pkt4_lasts", obs_last_cnt, 1);

        // 33 writes without ack: word 33 must be dropped
        do_reset();
        write_words(2'd0, 32'h1000, 33);
        check_eq("full_margin", slv_margin, 32'd0);
        check_eq("full_ready",  ch_ready,   1'b0);
        for (int p = 0; p < 8; p++) begin
            wait_req(1'b1, 2'd0);
            tick(1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 1'b0);
            idle_cycles(1'b1, 2'd0, 5);
        end
        check_eq("drained_margin", slv_margin, 32'd32);
        check_eq("drained_noreq",  slv_req,    1'b0);

        // Full FIFO, 32-word packet, writes held during SEND
        do_reset();
        write_words(2'd3, 32'h2000, 32);
        wait_req(1'b1, 2'd3);
        tick(1'b1, 2'd3, 32'h3000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 32; i++) begin
            tick(1'b1, 2'd3, 32'h3001 + i, 1'b1, 1'b0, 1'b0);
            check_eq("send_margin", slv_margin, 32'd0);
        end
        idle_cycles(1'b1, 2'd3, 3);
        wait_req(1'b1, 2'd3);
        tick(1'b1, 2'd3, 32'd0, 1'b0, 1'b1, 1'b0);
        idle_cycles(1'b1, 2'd3, 36);

        // slv_en dropped after ack, 8-word packet still completes
        do_reset();
        write_words(2'd1, 32'h4000, 12);
        wait_req(1'b1, 2'd1);
        tick(1'b1, 2'd1, 32'd0, 1'b0, 1'b1, 1'b0);
        obs_val_cnt = 0; obs_req_cnt = 0;
        tick(1'b0, 2'd1, 32'h5555, 1'b1, 1'b0, 1'b0);
        check_eq("en_off_ready", ch_ready, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 2'd1, 32'h5555, 1'b1, 1'b0, 1'b0);
        check_eq("en_off_vals",  obs_val_cnt, 8);
        check_eq("en_off_noreq", obs_req_cnt, 0);

        // Reset on 3rd word of a 16-word packet
        do_reset();
        write_words(2'd2, 32'h6000, 16);
        wait_req(1'b1, 2'd2);
        tick(1'b1, 2'd2, 32'd0, 1'b0, 1'b1, 1'b0);
        obs_val_cnt = 0;
        for (int i = 0; i < 10 && obs_val_cnt < 3; i++) tick(1'b1, 2'd2, 32'd0, 1'b0, 1'b0, 1'b0);
        check_eq("third_word", slv_data, 32'h6002);
        obs_last_cnt = 0;
        tick(1'b1, 2'd2, 32'd0, 1'b0, 1'b0, 1'b1);
        check_eq("abort_val",    slv_val,    1'b0);
        check_eq("abort_margin", slv_margin, 32'd32);
        idle_cycles(1'b1, 2'd2, 5);
        check_eq("abort_nolast", obs_last_cnt, 0);

        // pkt_len_sel changed while in REQ: packet stays 4 words
        do_reset();
        write_words(2'd0, 32'h7000, 6);
        wait_req(1'b1, 2'd0);
        idle_cycles(1'b1, 2'd3, 2);
        obs_val_cnt = 0;
        tick(1'b1, 2'd3, 32'd0, 1'b0, 1'b1, 1'b0);
        idle_cycles(1'b1, 2'd3, 10);
        check_eq("len_locked", obs_val_cnt, 4);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 15) != 0),
                 2'($urandom_range(0, 3)),
                 $urandom,
                 ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 499) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
